divisor_restas: RTL and testbench



---
 rtl/divisor_restas_pkg.sv | 15 +
 rtl/divisor_restas_if.sv | 24 ++
 rtl/divisor_restas_datapath.sv | 81 ++++++++
 rtl/divisor_restas.sv | 62 ++++++
 tb/tb_divisor_restas.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/divisor_restas_pkg.sv
// divisor_restas shared definitions
// State encoding shared with the accumulate block
package divisor_restas_pkg;

  localparam int DIV_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_SUB   = 3'd2,
    S_FIN   = 3'd3,
    S_ERR   = 3'd4
  } state_e;

endpackage

// File: rtl/divisor_restas_if.sv
// divisor_restas request/result bundle
// Master drives operands, slave returns results
interface divisor_restas_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             done;
  logic             busy;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, done, busy, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, done, busy, div_by_zero
  );
endinterface

// File: rtl/divisor_restas_datapath.sv
// divisor_restas datapath: R/D/Q working regs,
// subtractor, compare flags and result registers
module divisor_restas_datapath #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             sub_i,
  input  logic             fin_i,
  input  logic             clr_i,
  input  logic             err_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             ge_o,
  output logic             zero_o,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             dbz_o
);
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  assign ge_o   = (r_q >= d_q);
  assign zero_o = (d_q == '0);
  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign dbz_o  = dbz_q;

  // Next-state selection from controller strobes
  always_comb begin
    r_d    = r_q;
    d_d    = d_q;
    q_d    = q_q;
    quot_d = quot_q;
    rem_d  = rem_q;
    dbz_d  = dbz_q;
    if (load_i) begin
      r_d = dividend_i;
      d_d = divisor_i;
      q_d = '0;
    end
    if (sub_i) begin
      r_d = r_q - d_q;
      q_d = q_q + 1'b1;
    end
    if (fin_i) begin
      quot_d = q_q;
      rem_d  = r_q;
    end
    if (clr_i) dbz_d = 1'b0;
    if (err_i) begin
      quot_d = '1;
      rem_d  = r_q;
      dbz_d  = 1'b1;
    end
  end

  // Register update with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_q    <= '0;
      d_q    <= '0;
      q_q    <= '0;
      quot_q <= '0;
      rem_q  <= '0;
      dbz_q  <= 1'b0;
    end else begin
      r_q    <= r_d;
      d_q    <= d_d;
      q_q    <= q_d;
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dbz_q  <= dbz_d;
    end
  end
endmodule

// File: rtl/divisor_restas.sv
// divisor_restas: restoring-free repeated-subtraction
// unsigned divider, ASM controller + datapath
module divisor_restas
  import divisor_restas_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input logic              clk,
  input logic              rst,
  divisor_restas_if.slave  bus
);
  state_e     state_q;
  logic       ge, zero;
  logic       load, sub, fin, clr, err;

  assign load = (state_q == S_IDLE) && bus.start;
  assign sub  = (state_q == S_SUB);
  assign fin  = (state_q == S_CHECK) && !zero && !ge;
  assign clr  = (state_q == S_FIN);
  assign err  = (state_q == S_ERR);

  assign bus.done = (state_q == S_FIN) ||
                    (state_q == S_ERR);
  assign bus.busy = (state_q != S_IDLE);

  // Controller: zero check first, then compare
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE:  if (bus.start) state_q <= S_CHECK;
        S_CHECK: begin
          if (zero)    state_q <= S_ERR;
          else if (ge) state_q <= S_SUB;
          else         state_q <= S_FIN;
        end
        S_SUB:   state_q <= S_CHECK;
        S_FIN:   state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  divisor_restas_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .rst        (rst),
    .load_i     (load),
    .sub_i      (sub),
    .fin_i      (fin),
    .clr_i      (clr),
    .err_i      (err),
    .dividend_i (bus.dividend),
    .divisor_i  (bus.divisor),
    .ge_o       (ge),
    .zero_o     (zero),
    .quot_o     (bus.quotient),
    .rem_o      (bus.remainder),
    .dbz_o      (bus.div_by_zero)
  );
endmodule

// File: tb/tb_divisor_restas.sv
// divisor_restas directed bench
// Edge 0 is the edge just before start is raised
module tb_divisor_restas;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   ecnt = 0;
  int   e0 = 0;
  int   dcnt;
  logic [15:0] pq = '0;
  logic [15:0] pr = '0;
  logic        pz = 1'b0;

  divisor_restas_if #(.WIDTH(16)) bus ();

  divisor_restas #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic go(logic [15:0] a, logic [15:0] b);
    @(negedge clk);
    e0 = ecnt;
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
  endtask

  task automatic wait_done(string tag, int budget);
    int n;
    n = 0;
    while (bus.done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.done !== 1'b1) chk({tag, " timeout"}, 0, 1);
  endtask

  task automatic run_op(string tag, logic [15:0] a,
                        logic [15:0] b, logic [15:0] eq,
                        logic [15:0] er, logic ez, int lat);
    go(a, b);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dividend = ~a;
    bus.divisor = ~b;
    chk({tag, " busy"}, bus.busy, 1);
    wait_done(tag, lat + 20);
    chk({tag, " lat"}, ecnt - e0, lat);
    if (!ez) begin
      chk({tag, " q@done"}, bus.quotient, eq);
      chk({tag, " r@done"}, bus.remainder, er);
    end else begin
      chk({tag, " oldq@done"}, bus.quotient, pq);
    end
    chk({tag, " oldz@done"}, bus.div_by_zero, pz);
    @(negedge clk);
    chk({tag, " done1"}, bus.done, 0);
    chk({tag, " idle"}, bus.busy, 0);
    chk({tag, " q"}, bus.quotient, eq);
    chk({tag, " r"}, bus.remainder, er);
    chk({tag, " z"}, bus.div_by_zero, ez);
    pq = eq;
    pr = er;
    pz = ez;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", bus.busy, 0);
    chk("rst done", bus.done, 0);
    chk("rst q", bus.quotient, 0);
    chk("rst r", bus.remainder, 0);
    chk("rst z", bus.div_by_zero, 0);
    rst = 1'b0;

    run_op("100/7", 100, 7, 14, 2, 0, 30);
    run_op("5/9", 5, 9, 0, 5, 0, 2);
    run_op("0/3", 0, 3, 0, 0, 0, 2);
    run_op("40/0", 40, 0, 16'hFFFF, 40, 1, 2);
    run_op("40/8", 40, 8, 5, 0, 0, 12);
    run_op("0/0", 0, 0, 16'hFFFF, 0, 1, 2);
    run_op("65535/4", 16'hFFFF, 4, 16383, 3, 0, 32768);
    run_op("12/12", 12, 12, 1, 0, 0, 4);

    // start while busy is ignored, held start restarts
    go(50, 5);
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.dividend = 9;
    bus.divisor = 2;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    wait_done("50/5", 60);
    chk("50/5 lat", ecnt - e0, 22);
    chk("50/5 q", bus.quotient, 10);
    chk("50/5 r", bus.remainder, 0);
    @(negedge clk);
    chk("held idle", bus.busy, 0);
    @(negedge clk);
    chk("held accept", bus.busy, 1);
    wait_done("9/2", 60);
    chk("9/2 lat", ecnt - e0, 33);
    chk("9/2 q", bus.quotient, 4);
    chk("9/2 r", bus.remainder, 1);
    bus.start = 1'b0;
    @(negedge clk);
    chk("9/2 done1", bus.done, 0);
    @(negedge clk);
    chk("9/2 stop", bus.busy, 0);

    // reset mid-operation aborts with no done
    go(1000, 3);
    @(negedge clk);
    bus.start = 1'b0;
    while (ecnt - e0 < 9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid rst state", dut.state_q, 0);
    chk("mid rst busy", bus.busy, 0);
    chk("mid rst done", bus.done, 0);
    chk("mid rst q", bus.quotient, 0);
    chk("mid rst r", bus.remainder, 0);
    rst = 1'b0;
    dcnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus.done === 1'b1) dcnt++;
    end
    chk("no done after rst", dcnt, 0);
    pq = '0;
    pr = '0;
    pz = 1'b0;
    run_op("7/2", 7, 2, 3, 1, 0, 8);

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end
endmodule
